// File: rtl/alu_retire_stage_pkg.sv
// Shared types for the ALU retire stage: flag layout, retire entry record and
// buffer depth.
package alu_retire_stage_pkg;

    typedef logic [63:0] long_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic sn;
    } flags_t;

    typedef struct packed {
        long_t      result;
        flags_t     flags;
        logic [4:0] rd;
        logic       wr_reg;
        logic       wr_flags;
        logic [7:0] exc;
    } retire_entry_t;

    localparam int RETIRE_DEPTH = 2;

endpackage

// File: rtl/alu_retire_stage_fifo.sv
// In-order buffer of retire entries with per-slot valid bits so that pending
// flag writers can be detected without decoding pointers.
module retire_fifo
    import alu_retire_stage_pkg::*;
#(
    parameter int DEPTH = RETIRE_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  retire_entry_t wr_entry,
    output retire_entry_t head,
    output logic          full,
    output logic          empty,
    output logic          any_wr_flags
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    retire_entry_t  mem_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  wr_ptr_r;
    logic [CW-1:0]  count_r;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Storage, pointers and occupancy; flush drops everything but keeps storage contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            valid_r  <= '0;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            valid_r  <= '0;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r]   <= wr_entry;
                valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= next_ptr(wr_ptr_r);
            end
            if (pop) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= next_ptr(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Any buffered entry that will write the flag register.
    always_comb begin
        any_wr_flags = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_wr_flags = any_wr_flags | (valid_r[i] & mem_r[i].wr_flags);
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == CW'(0));

endmodule

// File: rtl/alu_retire_stage.sv
// ALU retire stage: buffers results, commits flags and counts retired
// instructions as entries leave through the writeback port.
module alu_retire_stage
    import alu_retire_stage_pkg::*;
#(
    parameter int DEPTH = RETIRE_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  long_t      in_result,
    input  flags_t     in_flags,
    input  logic [4:0] in_rd,
    input  logic       in_wr_reg,
    input  logic       in_wr_flags,
    input  logic [7:0] in_exc,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output long_t      out_result,
    output logic [4:0] out_rd,
    output logic       out_wr_reg,
    output logic [7:0] out_exc,
    output flags_t     flags,
    output logic       carry_o,
    output logic       flag_busy,
    output long_t      retire_count
);

    logic          push_s;
    logic          pop_s;
    logic          commit_s;
    logic          full_s;
    logic          empty_s;
    logic          any_wr_flags_s;
    retire_entry_t wr_entry_s;
    retire_entry_t head_s;
    flags_t        flags_r;
    long_t         retire_count_r;

    assign wr_entry_s = '{result:   in_result,
                          flags:    in_flags,
                          rd:       in_rd,
                          wr_reg:   in_wr_reg,
                          wr_flags: in_wr_flags,
                          exc:      in_exc};

    // in_ready depends only on stored occupancy, never on out_ready.
    assign in_ready  = ~full_s;
    assign out_valid = ~empty_s & ~flush;
    assign push_s    = in_valid & in_ready & ~flush;
    assign pop_s     = out_valid & out_ready;
    assign commit_s  = pop_s & (head_s.exc == 8'h00);

    retire_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push_s),
        .pop         (pop_s),
        .flush       (flush),
        .wr_entry    (wr_entry_s),
        .head        (head_s),
        .full        (full_s),
        .empty       (empty_s),
        .any_wr_flags(any_wr_flags_s)
    );

    // Architectural flags and retired-instruction counter, updated only on a clean commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_r        <= '0;
            retire_count_r <= '0;
        end else begin
            if (commit_s && head_s.wr_flags) begin
                flags_r <= head_s.flags;
            end
            if (commit_s) begin
                retire_count_r <= retire_count_r + 64'd1;
            end
        end
    end

    assign out_result   = head_s.result;
    assign out_rd       = head_s.rd;
    assign out_wr_reg   = head_s.wr_reg;
    assign out_exc      = head_s.exc;
    assign flags        = flags_r;
    assign carry_o      = flags_r.c;
    assign flag_busy    = any_wr_flags_s;
    assign retire_count = retire_count_r;

endmodule

// File: tb/tb_alu_retire_stage.sv
// Directed self-checking bench for alu_retire_stage; one task per scenario.
module tb_alu_retire_stage;
    import alu_retire_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic [3:0]  in_flags;
    logic [4:0]  in_rd;
    logic        in_wr_reg;
    logic        in_wr_flags;
    logic [7:0]  in_exc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wr_reg;
    logic [7:0]  out_exc;
    logic [3:0]  flags;
    logic        carry_o;
    logic        flag_busy;
    logic [63:0] retire_count;

    int n_cmp;
    int n_bad;

    alu_retire_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_flags    (in_flags),
        .in_rd       (in_rd),
        .in_wr_reg   (in_wr_reg),
        .in_wr_flags (in_wr_flags),
        .in_exc      (in_exc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_wr_reg  (out_wr_reg),
        .out_exc     (out_exc),
        .flags       (flags),
        .carry_o     (carry_o),
        .flag_busy   (flag_busy),
        .retire_count(retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] r, input logic [3:0] f,
                         input logic wf, input logic [7:0] e);
        in_valid    = v;
        in_result   = r;
        in_flags    = f;
        in_rd       = r[4:0];
        in_wr_reg   = 1'b1;
        in_wr_flags = wf;
        in_exc      = e;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (flag_busy !== 1'b0) begin n_bad++; $display("FAIL reset_flag_busy: got %b want 0", flag_busy); end
        n_cmp++; if (carry_o !== 1'b0) begin n_bad++; $display("FAIL reset_carry: got %b want 0", carry_o); end
        n_cmp++; if (retire_count !== 64'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", retire_count); end
    endtask

    task automatic test_commit_carry();
        out_ready = 1'b1;
        drive(1'b1, 64'h5, 4'b0010, 1'b1, 8'h00);
        step();
        drive(1'b0, 64'h0, 4'b0000, 1'b0, 8'h00);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_result !== 64'h5) begin n_bad++; $display("FAIL basic_result: got %h want 5", out_result); end
        n_cmp++; if (flag_busy !== 1'b1) begin n_bad++; $display("FAIL basic_flag_busy: got %b want 1", flag_busy); end
        n_cmp++; if (carry_o !== 1'b0) begin n_bad++; $display("FAIL basic_carry_early: got %b want 0", carry_o); end
        step();
        n_cmp++; if (carry_o !== 1'b1) begin n_bad++; $display("FAIL basic_carry: got %b want 1", carry_o); end
        n_cmp++; if (flags !== 4'b0010) begin n_bad++; $display("FAIL basic_flags: got %b want 0010", flags); end
        n_cmp++; if (retire_count !== 64'd1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", retire_count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 64'h11, 4'b1111, 1'b0, 8'h00);
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_one: got %b want 1", in_ready); end
        drive(1'b1, 64'h22, 4'b1111, 1'b0, 8'h00);
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_full: got %b want 0", in_ready); end
        drive(1'b1, 64'h33, 4'b1111, 1'b0, 8'h00);
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_still_full: got %b want 0", in_ready); end
        n_cmp++; if (out_result !== 64'h11) begin n_bad++; $display("FAIL b2b_head_a: got %h want 11", out_result); end
        drive(1'b0, 64'h0, 4'b0000, 1'b0, 8'h00);
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_result !== 64'h22) begin n_bad++; $display("FAIL b2b_head_b: got %h want 22", out_result); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after_pop: got %b want 1", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_third_dropped: got %b want 0", out_valid); end
        n_cmp++; if (retire_count !== 64'd3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", retire_count); end
        n_cmp++; if (flags !== 4'b0010) begin n_bad++; $display("FAIL b2b_flags_kept: got %b want 0010", flags); end
    endtask

    task automatic test_push_pop();
        out_ready = 1'b0;
        drive(1'b1, 64'h44, 4'b0000, 1'b0, 8'h00);
        step();
        drive(1'b1, 64'h55, 4'b0000, 1'b0, 8'h00);
        out_ready = 1'b1;
        #1;
        n_cmp++; if (out_result !== 64'h44) begin n_bad++; $display("FAIL pp_head_old: got %h want 44", out_result); end
        step();
        drive(1'b0, 64'h0, 4'b0000, 1'b0, 8'h00);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL pp_valid: got %b want 1", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL pp_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_result !== 64'h55) begin n_bad++; $display("FAIL pp_head_new: got %h want 55", out_result); end
        n_cmp++; if (retire_count !== 64'd4) begin n_bad++; $display("FAIL pp_count_mid: got %0d want 4", retire_count); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL pp_drained: got %b want 0", out_valid); end
        n_cmp++; if (retire_count !== 64'd5) begin n_bad++; $display("FAIL pp_count: got %0d want 5", retire_count); end
    endtask

    task automatic test_exception();
        out_ready = 1'b0;
        drive(1'b1, 64'h66, 4'b1000, 1'b1, 8'h0D);
        step();
        drive(1'b0, 64'h0, 4'b0000, 1'b0, 8'h00);
        n_cmp++; if (out_exc !== 8'h0D) begin n_bad++; $display("FAIL exc_code: got %h want 0d", out_exc); end
        n_cmp++; if (out_result !== 64'h66) begin n_bad++; $display("FAIL exc_result: got %h want 66", out_result); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (flags !== 4'b0010) begin n_bad++; $display("FAIL exc_flags: got %b want 0010", flags); end
        n_cmp++; if (retire_count !== 64'd5) begin n_bad++; $display("FAIL exc_count: got %0d want 5", retire_count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL exc_popped: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 64'h77, 4'b1000, 1'b1, 8'h00);
        step();
        drive(1'b1, 64'h88, 4'b0001, 1'b1, 8'h00);
        step();
        n_cmp++; if (flag_busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy_pre: got %b want 1", flag_busy); end
        drive(1'b1, 64'h99, 4'b0100, 1'b1, 8'h00);
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        step();
        flush = 1'b0;
        drive(1'b0, 64'h0, 4'b0000, 1'b0, 8'h00);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b want 1", in_ready); end
        n_cmp++; if (flag_busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b want 0", flag_busy); end
        n_cmp++; if (flags !== 4'b0010) begin n_bad++; $display("FAIL flush_flags: got %b want 0010", flags); end
        n_cmp++; if (retire_count !== 64'd5) begin n_bad++; $display("FAIL flush_count: got %0d want 5", retire_count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 64'hAA, 4'b1000, 1'b1, 8'h00);
        step();
        drive(1'b1, 64'hBB, 4'b0001, 1'b1, 8'h00);
        step();
        drive(1'b0, 64'h0, 4'b0000, 1'b0, 8'h00);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_full: got %b want 0", in_ready); end
        rst_n     = 1'b0;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
        n_cmp++; if (flag_busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", flag_busy); end
        n_cmp++; if (carry_o !== 1'b0) begin n_bad++; $display("FAIL rmid_carry: got %b want 0", carry_o); end
        n_cmp++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL rmid_flags: got %b want 0000", flags); end
        n_cmp++; if (retire_count !== 64'd0) begin n_bad++; $display("FAIL rmid_count: got %0d want 0", retire_count); end
        n_cmp++; if (out_result !== 64'd0) begin n_bad++; $display("FAIL rmid_storage: got %h want 0", out_result); end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 64'h0, 4'b0000, 1'b0, 8'h00);
        test_reset();
        test_commit_carry();
        test_back_to_back();
        test_push_pop();
        test_exception();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_retire_stage.md
ALU_RETIRE_STAGE -- requirements
Module: alu_retire_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered retire entries (fixed 2 in this revision).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  ALU op presented.
REQ-005 SHALL have port in_ready  output  1  stage can accept.
REQ-006 SHALL have port in_result  input  64 (long_t)  ALU result.
REQ-007 SHALL have port in_flags  input  4 (flags_t: z,n,c,sn)  ALU flag outputs.
REQ-008 SHALL have port in_rd  input  5  destination register index.
REQ-009 SHALL have port in_wr_reg / in_wr_flags  input  1 each  write-enable for register / flags.
REQ-010 SHALL have port in_exc  input  8  exception code; 0 = none.
REQ-011 SHALL have port flush  input  1  discard all buffered entries.
REQ-012 SHALL have ports out_valid output 1, out_ready input 1, out_result 64, out_rd 5, out_wr_reg 1, out_exc 8: writeback port carrying the head entry.
REQ-013 SHALL have port flags  output  4  architectural flag register.
REQ-014 SHALL have port carry_o  output  1  equals flags.c; drives ALU i_carry.
REQ-015 SHALL have port flag_busy  output  1  a buffered entry will write flags.
REQ-016 SHALL have port retire_count  output  64  committed-instruction counter.

Function
REQ-017 SHALL hold entries in an in-order FIFO of DEPTH; push on in_valid&in_ready, pop on out_valid&out_ready.
REQ-018 SHALL drive in_ready = (count != DEPTH) from registered state only; no combinational path from out_ready.
REQ-019 SHALL drive out_valid = (count != 0) & ~flush; out_* fields from head entry.
REQ-020 SHALL have latency 1: an entry pushed in cycle T is presented at out in T+1 at the earliest.
REQ-021 SHALL, on simultaneous push and pop with count=1, keep count=1 with the new entry at head at T+1.
REQ-022 SHALL, on pop of an entry with exc=0, write in_flags captured in that entry to flags if wr_flags=1 and increment retire_count by 1 (wrapping modulo 2^64).
REQ-023 SHALL, on pop of an entry with exc!=0, present it unchanged and update neither flags nor retire_count.
REQ-024 SHALL assert flag_busy combinationally whenever any valid entry has wr_flags=1, so upstream holds flag-reading ops.
REQ-025 SHALL, with flush=1 in cycle T, ignore any push and pop in T, update neither flags nor retire_count, and have count=0 at T+1.
REQ-026 SHALL update carry_o one cycle after the committing pop, never from an unpopped entry.

Reset
REQ-027 SHALL, with rst_n=0 at a clock edge, set count=0, flags=0, retire_count=0 and all entry storage to 0, overriding push, pop and flush.
REQ-028 SHALL, one cycle after reset, drive in_ready=1, out_valid=0, flag_busy=0, carry_o=0.

Structure
REQ-029 SHALL take flags_t, retire_entry_t (result, flags, rd, wr_reg, wr_flags, exc) and RETIRE_DEPTH from the shared types package; long_t reused.
REQ-030 SHALL isolate the FIFO in one sub-module, retire_fifo, leaving commit, flag and counter logic at top.

Verification
REQ-031 SHALL cover: reset then push result=0x5, flags c=1, wr_flags=1, out_ready=1 -> out_valid at T+1, carry_o=1 at T+2, retire_count=1.
REQ-032 SHALL cover: out_ready=0, three back-to-back pushes -> in_ready=0 after second, third held, count=2, order preserved.
REQ-033 SHALL cover: count=1, simultaneous push/pop -> count stays 1, popped then pushed values appear in order.
REQ-034 SHALL cover: pop entry with exc=0x0D, wr_flags=1, flags z=1 -> flags unchanged, retire_count unchanged, out_exc=0x0D.
REQ-035 SHALL cover: count=2 with wr_flags entries, flush=1 with out_ready=1 -> out_valid=0 that cycle, count=0, flag_busy=0, flags unchanged.
REQ-036 SHALL cover: rst_n=0 mid-stream with count=2 -> all outputs at reset values next cycle.
